// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard used by decode for RAW hazard stalls.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*$clog2(NREGS)-1:0] rs_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rs_data_o,
    output logic [NUM_RD-1:0]        rs_busy_o,
    input  logic [1:0]               wr_en_i,
    input  logic [2*$clog2(NREGS)-1:0] wr_addr_i,
    input  logic [2*XLEN-1:0]        wr_data_i,
    input  logic                     iss_en_i,
    input  logic [$clog2(NREGS)-1:0] iss_addr_i,
    input  logic                     flush_i,
    output logic                     busy_any_o
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            we0, we1, iss_ok;

    assign wa0 = wr_addr_i[0 +: AW];
    assign wa1 = wr_addr_i[AW +: AW];
    assign wd0 = wr_data_i[0 +: XLEN];
    assign wd1 = wr_data_i[XLEN +: XLEN];

    // A hardwired-zero register swallows writes and issues so it never looks pending.
    assign we0    = wr_en_i[0] && !((ZERO_REG != 0) && (wa0 == '0));
    assign we1    = wr_en_i[1] && !((ZERO_REG != 0) && (wa1 == '0));
    assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0) begin
                regs[wa0] <= wd0;
            end
            if (we1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Set beats clear: a writeback retires the older producer while a same-cycle issue stays pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (flush_i) begin
                    busy[r] <= 1'b0;
                end else if (iss_ok && (iss_addr_i == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_any_o = |busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rs_addr_i[k*AW +: AW];

        // Bypass is suppressed while in reset so reads report zero immediately.
        always_comb begin
            data = regs[addr];
            if ((BYPASS != 0) && rst_ni) begin
                if (we0 && (wa0 == addr)) begin
                    data = wd0;
                end
                if (we1 && (wa1 == addr)) begin
                    data = wd1;
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end
        end

        assign rs_data_o[k*XLEN +: XLEN] = data;
        assign rs_busy_o[k]              = busy[addr];
    end

endmodule
